// File: rtl/sv_timer_pkg.sv
// Shared register map, bit indices and TCTRL layout for sv_irq_timer.
// Build option: define SV_TIMER_PERIODIC_EN to implement the periodic bit TCTRL[2].
package sv_timer_pkg;

  localparam logic [3:0] REG_CTRL       = 4'h0;
  localparam logic [3:0] REG_STATUS     = 4'h1;
  localparam logic [3:0] REG_ACK        = 4'h2;
  localparam logic [3:0] REG_TIMER_BASE = 4'h4;

  localparam int CTRL_GIE       = 0;
  localparam int CTRL_DMA_IE    = 1;
  localparam int TCTRL_RUN      = 0;
  localparam int TCTRL_SLOW     = 1;
  localparam int TCTRL_PERIODIC = 2;
  localparam int TCTRL_IRQ_EN   = 3;
  localparam int PEND_DMA       = 7;

`ifdef SV_TIMER_PERIODIC_EN
  localparam logic PERIODIC_EN = 1'b1;
`else
  localparam logic PERIODIC_EN = 1'b0;
`endif

  typedef struct packed {
    logic irq_en;
    logic periodic;
    logic slow;
    logic run;
  } tctrl_t;

  // Without periodic support the bit is forced to 0, so it reads back 0 and has no effect.
  function automatic tctrl_t tctrl_from_bits(input logic [3:0] b);
    tctrl_t r;
    r.run      = b[TCTRL_RUN];
    r.slow     = b[TCTRL_SLOW];
    r.periodic = b[TCTRL_PERIODIC] & PERIODIC_EN;
    r.irq_en   = b[TCTRL_IRQ_EN];
    return r;
  endfunction

endpackage

// File: rtl/sv_timer_chan.sv
// One timer channel: prescaler, 8-bit down-counter with reload, TCTRL register and expire pulse.
// Periodic behaviour depends on SV_TIMER_PERIODIC_EN through sv_timer_pkg::tctrl_from_bits.
module sv_timer_chan
  import sv_timer_pkg::*;
#(
  parameter int unsigned        PRESC_W    = 14,
  parameter logic [PRESC_W-1:0] PRESC_FAST = 14'h00FF,
  parameter logic [PRESC_W-1:0] PRESC_SLOW = 14'h3FFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_i,
  input  logic       load_we_i,
  input  logic       tctrl_we_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] count_o,
  output logic [3:0] tctrl_o,
  output logic       expire_o
);

  localparam logic [PRESC_W-1:0] PRESC_ZERO = PRESC_W'(1'b0);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1'b1);

  logic [PRESC_W-1:0] presc_q, presc_d, presc_rl_s;
  logic [7:0]         count_q, count_d;
  logic [7:0]         reload_q, reload_d;
  tctrl_t             tctrl_q, tctrl_d;
  logic               tick_s;
  logic               expire_s;

  // Next-state for prescaler, counter and TCTRL; a LOAD write overrides a same-cycle tick.
  always_comb begin
    presc_rl_s = tctrl_q.slow ? PRESC_SLOW : PRESC_FAST;
    presc_d    = presc_q;
    count_d    = count_q;
    reload_d   = reload_q;
    tctrl_d    = tctrl_q;
    tick_s     = 1'b0;
    expire_s   = 1'b0;

    if (ce_i && tctrl_q.run) begin
      if (presc_q == PRESC_ZERO) begin
        tick_s  = 1'b1;
        presc_d = presc_rl_s;
      end else begin
        presc_d = presc_q - PRESC_ONE;
      end
    end else begin
      presc_d = presc_q;
    end

    if (load_we_i) begin
      reload_d = wdata_i;
      count_d  = wdata_i;
      presc_d  = presc_rl_s;
      expire_s = (wdata_i == 8'h00);
    end else if (tick_s && (count_q != 8'h00)) begin
      if (count_q == 8'h01) begin
        expire_s = 1'b1;
        count_d  = (tctrl_q.periodic && (reload_q != 8'h00)) ? reload_q : 8'h00;
      end else begin
        count_d = count_q - 8'h01;
      end
    end else begin
      count_d = count_q;
    end

    if (tctrl_we_i) begin
      tctrl_d = tctrl_from_bits(wdata_i[3:0]);
    end else begin
      tctrl_d = tctrl_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q  <= PRESC_ZERO;
      count_q  <= 8'h00;
      reload_q <= 8'h00;
      tctrl_q  <= 4'h0;
    end else begin
      presc_q  <= presc_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tctrl_q  <= tctrl_d;
    end
  end

  assign count_o  = count_q;
  assign tctrl_o  = tctrl_q;
  assign expire_o = expire_s;

endmodule

// File: rtl/sv_irq_timer.sv
// Supervision timer/IRQ controller: register decode, pending latch, irq and read data.
// Build option: SV_TIMER_PERIODIC_EN enables periodic timers (TCTRL[2]).
module sv_irq_timer
  import sv_timer_pkg::*;
#(
  parameter int unsigned        NUM_TIMERS = 2,
  parameter int unsigned        PRESC_W    = 14,
  parameter logic [PRESC_W-1:0] PRESC_FAST = 14'h00FF,
  parameter logic [PRESC_W-1:0] PRESC_SLOW = 14'h3FFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       cs,
  input  logic       we,
  input  logic [3:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       dma_done,
  output logic       irq
);

  logic                  wr_s, rd_s;
  logic [1:0]            ctrl_q, ctrl_d;
  logic [7:0]            pend_q, pend_d, set_s;
  logic [7:0]            dout_q, dout_d;
  logic [7:0]            rdata_s, trdata_s;
  logic                  thit_s;
  logic [NUM_TIMERS-1:0] cnt_hit_s, tc_hit_s, load_we_s, tctrl_we_s, expire_s, irq_en_s;
  logic [7:0]            count_s [NUM_TIMERS];
  logic [3:0]            tctrl_s [NUM_TIMERS];

  assign wr_s = cs & ce & we;
  assign rd_s = cs & ce & ~we;

  for (genvar t = 0; t < NUM_TIMERS; t++) begin : g_chan
    localparam logic [3:0] CNT_ADDR = REG_TIMER_BASE + 4'(2 * t);
    localparam logic [3:0] TC_ADDR  = CNT_ADDR + 4'h1;

    assign cnt_hit_s[t]  = (addr == CNT_ADDR);
    assign tc_hit_s[t]   = (addr == TC_ADDR);
    assign load_we_s[t]  = wr_s & cnt_hit_s[t];
    assign tctrl_we_s[t] = wr_s & tc_hit_s[t];
    assign irq_en_s[t]   = tctrl_s[t][TCTRL_IRQ_EN];

    sv_timer_chan #(
      .PRESC_W   (PRESC_W),
      .PRESC_FAST(PRESC_FAST),
      .PRESC_SLOW(PRESC_SLOW)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .ce_i      (ce),
      .load_we_i (load_we_s[t]),
      .tctrl_we_i(tctrl_we_s[t]),
      .wdata_i   (din),
      .count_o   (count_s[t]),
      .tctrl_o   (tctrl_s[t]),
      .expire_o  (expire_s[t])
    );
  end

  // Read-data mux; any offset not claimed by a register returns FF.
  always_comb begin
    trdata_s = 8'h00;
    thit_s   = 1'b0;
    for (int t = 0; t < NUM_TIMERS; t++) begin
      trdata_s = trdata_s | (cnt_hit_s[t] ? count_s[t] : 8'h00)
                          | (tc_hit_s[t] ? {4'h0, tctrl_s[t]} : 8'h00);
      thit_s   = thit_s | cnt_hit_s[t] | tc_hit_s[t];
    end
    rdata_s = 8'hFF;
    case (addr)
      REG_CTRL:            rdata_s = {6'b000000, ctrl_q};
      REG_STATUS, REG_ACK: rdata_s = pend_q;
      default:             rdata_s = thit_s ? trdata_s : 8'hFF;
    endcase
  end

  // Next-state for CTRL, pending and dout; set events are OR-ed after clears so they win.
  always_comb begin
    set_s                   = 8'h00;
    set_s[PEND_DMA]         = dma_done;
    set_s[NUM_TIMERS-1:0]   = expire_s;

    if (wr_s && (addr == REG_STATUS)) begin
      pend_d = pend_q & ~din;
    end else if (rd_s && (addr == REG_ACK)) begin
      pend_d = 8'h00;
    end else begin
      pend_d = pend_q;
    end
    pend_d = pend_d | set_s;

    if (wr_s && (addr == REG_CTRL)) begin
      ctrl_d = din[1:0];
    end else begin
      ctrl_d = ctrl_q;
    end

    if (rd_s) begin
      dout_d = rdata_s;
    end else begin
      dout_d = dout_q;
    end
  end

  // Control, pending and read-data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= 2'b00;
      pend_q <= 8'h00;
      dout_q <= 8'hFF;
    end else begin
      ctrl_q <= ctrl_d;
      pend_q <= pend_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;
  assign irq  = ctrl_q[CTRL_GIE] &
                ((|(pend_q[NUM_TIMERS-1:0] & irq_en_s)) | (pend_q[PEND_DMA] & ctrl_q[CTRL_DMA_IE]));

endmodule

// File: tb/tb_sv_irq_timer.sv
// Bench for sv_irq_timer: directed scenarios with literal expectations, then random traffic
// compared every cycle against an event-level model.
module tb_sv_irq_timer;

  localparam int NT = 2;
`ifdef SV_TIMER_PERIODIC_EN
  localparam logic PER_EN = 1'b1;
`else
  localparam logic PER_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n, ce, cs, we, dma_done;
  logic [3:0] addr;
  logic [7:0] din, dout;
  logic       irq;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sv_irq_timer #(.NUM_TIMERS(NT)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .cs(cs), .we(we), .addr(addr),
    .din(din), .dout(dout), .dma_done(dma_done), .irq(irq)
  );

  // Model state: registers as the CPU sees them, plus ce cycles left until each timer's next tick.
  logic [1:0] m_ctrl;
  logic [7:0] m_pend, m_dout;
  logic [3:0] m_tc  [NT];
  logic [7:0] m_cnt [NT];
  logic [7:0] m_rel [NT];
  int         m_left[NT];

  function automatic logic [7:0] m_read(input logic [3:0] a);
    int ai, t;
    ai = a;
    if (ai == 0) return {6'd0, m_ctrl};
    if (ai == 1 || ai == 2) return m_pend;
    if (ai >= 4) begin
      t = (ai - 4) / 2;
      if (t < NT) return a[0] ? {4'd0, m_tc[t]} : m_cnt[t];
    end
    return 8'hFF;
  endfunction

  function automatic logic m_irq();
    logic any;
    any = 1'b0;
    for (int t = 0; t < NT; t++) any = any | (m_pend[t] & m_tc[t][3]);
    return m_ctrl[0] & (any | (m_pend[7] & m_ctrl[1]));
  endfunction

  function automatic int period(input logic slow);
    return slow ? 16384 : 256;
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    logic [7:0] set, np;
    logic       tick, acc_wr, acc_rd;
    if (!reset_n) begin
      m_ctrl = 2'd0; m_pend = 8'd0; m_dout = 8'hFF;
      for (int t = 0; t < NT; t++) begin
        m_tc[t] = 4'd0; m_cnt[t] = 8'd0; m_rel[t] = 8'd0; m_left[t] = 1;
      end
    end else begin
      acc_wr = cs && ce && we;
      acc_rd = cs && ce && !we;
      set    = {dma_done, 7'd0};
      if (acc_rd) m_dout = m_read(addr);
      for (int t = 0; t < NT; t++) begin
        tick = 1'b0;
        if (ce && m_tc[t][0]) begin
          m_left[t] = m_left[t] - 1;
          if (m_left[t] == 0) begin
            tick = 1'b1;
            m_left[t] = period(m_tc[t][1]);
          end
        end
        if (acc_wr && addr == 4'(4 + 2 * t)) begin
          m_rel[t] = din; m_cnt[t] = din; m_left[t] = period(m_tc[t][1]);
          if (din == 8'd0) set[t] = 1'b1;
        end else if (tick && m_cnt[t] != 8'd0) begin
          if (m_cnt[t] == 8'd1) begin
            set[t] = 1'b1;
            m_cnt[t] = (m_tc[t][2] && m_rel[t] != 8'd0) ? m_rel[t] : 8'd0;
          end else begin
            m_cnt[t] = m_cnt[t] - 8'd1;
          end
        end
        if (acc_wr && addr == 4'(5 + 2 * t)) m_tc[t] = {din[3], din[2] & PER_EN, din[1:0]};
      end
      np = m_pend;
      if (acc_wr && addr == 4'd1) np = np & ~din;
      if (acc_rd && addr == 4'd2) np = 8'd0;
      m_pend = np | set;
      if (acc_wr && addr == 4'd0) m_ctrl = din[1:0];
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("irq_vs_model", {7'd0, irq}, {7'd0, m_irq()});
      chk("dout_vs_model", dout, m_dout);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic bus(input logic w, input logic [3:0] a, input logic [7:0] d);
    cs = 1'b1; ce = 1'b1; we = w; addr = a; din = d;
    @(posedge clk); #2;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rdchk(input logic [3:0] a, input logic [7:0] exp, input string nm);
    bus(1'b0, a, 8'h00);
    chk(nm, dout, exp);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; ce = 1'b0; cs = 1'b0; we = 1'b0; addr = 4'd0; din = 8'd0; dma_done = 1'b0;
    #22;
    chk_en = 1'b1;
    chk("reset_irq", {7'd0, irq}, 8'h00);
    chk("reset_dout", dout, 8'hFF);
    @(posedge clk); #2;
    reset_n = 1'b1; ce = 1'b1;

    // Reset values and unmapped offsets
    rdchk(4'h0, 8'h00, "ctrl_after_reset");
    rdchk(4'h1, 8'h00, "status_after_reset");
    rdchk(4'h3, 8'hFF, "unmapped_3");
    rdchk(4'h8, 8'hFF, "unmapped_timer2");
    rdchk(4'hF, 8'hFF, "unmapped_F");

    // One-shot timer 0: LOAD=3 at fast rate fires after 3*256 ce
    bus(1'b1, 4'h0, 8'h01);
    bus(1'b1, 4'h5, 8'h09);
    bus(1'b1, 4'h4, 8'h03);
    n = 0;
    while (irq !== 1'b1 && n < 1100) begin @(posedge clk); #2; n++; end
    chk("irq_rise", {7'd0, irq}, 8'h01);
    chk("rise_latency_window", {7'd0, (n >= 512 && n <= 1024)}, 8'h01);
    rdchk(4'h2, 8'h01, "ack_read");
    chk("irq_after_ack", {7'd0, irq}, 8'h00);
    rdchk(4'h1, 8'h00, "status_after_ack");

    // Timer 1 with periodic requested: count sequence and TCTRL readback depend on the build
    bus(1'b1, 4'h7, 8'h0D);
    rdchk(4'h7, PER_EN ? 8'h0D : 8'h09, "tctrl1_readback");
    bus(1'b1, 4'h6, 8'h02);
    idle(100);
    rdchk(4'h6, 8'h02, "count1_first");
    idle(250);
    rdchk(4'h6, 8'h01, "count1_second");
    idle(260);
    rdchk(4'h6, PER_EN ? 8'h02 : 8'h00, "count1_third");
    rdchk(4'h1, 8'h02, "status_timer1");
    bus(1'b1, 4'h7, 8'h00);
    bus(1'b1, 4'h1, 8'hFF);
    rdchk(4'h1, 8'h00, "status_after_w1c");

    // LOAD=0 sets pending immediately even when stopped; irq gated by CTRL[0]
    bus(1'b1, 4'h0, 8'h00);
    bus(1'b1, 4'h5, 8'h08);
    bus(1'b1, 4'h4, 8'h00);
    rdchk(4'h1, 8'h01, "status_load0");
    chk("irq_gie_off", {7'd0, irq}, 8'h00);
    bus(1'b1, 4'h0, 8'h01);
    chk("irq_gie_on", {7'd0, irq}, 8'h01);
    bus(1'b1, 4'h1, 8'h01);
    chk("irq_after_w1c", {7'd0, irq}, 8'h00);

    // DMA done coinciding with a W1C of bit 7: the set wins
    bus(1'b1, 4'h0, 8'h00);
    dma_done = 1'b1; idle(1); dma_done = 1'b0;
    dma_done = 1'b1; bus(1'b1, 4'h1, 8'h80); dma_done = 1'b0;
    rdchk(4'h1, 8'h80, "status_dma_set_wins");
    bus(1'b1, 4'h0, 8'h03);
    chk("irq_dma", {7'd0, irq}, 8'h01);
    rdchk(4'h2, 8'h80, "ack_dma");
    chk("irq_after_dma_ack", {7'd0, irq}, 8'h00);

    // Reset one tick before expiry aborts the count
    bus(1'b1, 4'h0, 8'h01);
    bus(1'b1, 4'h5, 8'h09);
    bus(1'b1, 4'h4, 8'h02);
    idle(400);
    reset_n = 1'b0; idle(3); reset_n = 1'b1;
    idle(600);
    chk("irq_after_reset_abort", {7'd0, irq}, 8'h00);
    rdchk(4'h4, 8'h00, "count0_after_reset");
    rdchk(4'h1, 8'h00, "status_after_reset_abort");
    rdchk(4'h5, 8'h00, "tctrl0_after_reset");

    // Random traffic, checked every cycle by the model
    for (int i = 0; i < 20000; i++) begin
      ce       = ($urandom_range(0, 3) != 0);
      cs       = ($urandom_range(0, 19) == 0);
      we       = $urandom_range(0, 1);
      addr     = 4'($urandom_range(0, 15));
      din      = 8'($urandom);
      if (we && addr >= 4'h4 && !addr[0]) din = 8'($urandom_range(0, 3));
      if (we && addr >= 4'h4 && addr[0] && $urandom_range(0, 7) != 0) din[1] = 1'b0;
      dma_done = ($urandom_range(0, 63) == 0);
      if (i == 12000) reset_n = 1'b0;
      if (i == 12003) reset_n = 1'b1;
      @(posedge clk); #2;
    end
    cs = 1'b0; we = 1'b0; dma_done = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
